// File: rtl/mmio_frame_sequencer_if.sv
// CPU-side and MMIO-side bus bundle around the frame sequencer.
// master is the sequencer's view; slave is the view of the CPU/MMIO environment.
interface mmio_frame_sequencer_if;
  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;

  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_wren;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_stall;

  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_wren;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  cpu_address, cpu_data, cpu_wren, bus_rdata,
    output cpu_q, cpu_stall, bus_address, bus_wdata, bus_wren
  );

  modport slave (
    output cpu_address, cpu_data, cpu_wren, bus_rdata,
    input  cpu_q, cpu_stall, bus_address, bus_wdata, bus_wren
  );
endinterface

// File: rtl/mmio_frame_sequencer.sv
// MMIO bus initiator: on each accepted frame tick it stalls the CPU and copies
// eight coprocessor registers along a fixed routing table; otherwise passes the CPU through.
module mmio_frame_sequencer #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  ENTRY_MASK   = 8'hFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_tick,
  mmio_frame_sequencer_if.master mif,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun,
  output logic [15:0]           frame_count
);

  localparam int unsigned ADDR_W  = 13;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned LAT_W   = 2;
  localparam int unsigned ENTRIES = 8;

  typedef enum logic [2:0] {IDLE, READ, WRITE, SKIP, FINISH} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic [DATA_W-1:0] hold;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              wren_mux;
  logic [IDX_W-1:0]  idx_next;

  // Routing table: source register of each entry.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [IDX_W-1:0] i);
    case (i)
      3'd0: return 13'h1000;
      3'd1: return 13'h1000;
      3'd2: return 13'h1600;
      3'd3: return 13'h1080;
      3'd4: return 13'h1080;
      3'd5: return 13'h1680;
      3'd6: return 13'h1200;
      3'd7: return 13'h1280;
    endcase
  endfunction

  // Routing table: destination register of each entry.
  function automatic logic [ADDR_W-1:0] dst_addr(input logic [IDX_W-1:0] i);
    case (i)
      3'd0: return 13'h1600;
      3'd1: return 13'h1400;
      3'd2: return 13'h101C;
      3'd3: return 13'h1680;
      3'd4: return 13'h1480;
      3'd5: return 13'h109C;
      3'd6: return 13'h1010;
      3'd7: return 13'h1090;
    endcase
  endfunction

  assign idx_next = IDX_W'(idx + 1'b1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      lat_cnt     <= '0;
      hold        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      done <= 1'b0;
      if (frame_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (enable && frame_tick) begin
            idx     <= '0;
            lat_cnt <= '0;
            busy    <= 1'b1;
            state   <= ENTRY_MASK[0] ? READ : SKIP;
          end
        end
        READ: begin
          if (lat_cnt == LAT_W'(READ_LATENCY)) begin
            hold    <= mif.bus_rdata;
            lat_cnt <= '0;
            state   <= WRITE;
          end else begin
            lat_cnt <= LAT_W'(lat_cnt + 1'b1);
          end
        end
        WRITE, SKIP: begin
          // Last entry closes the sequence; busy drops as FINISH begins.
          if (idx == IDX_W'(ENTRIES - 1)) begin
            state       <= FINISH;
            busy        <= 1'b0;
            done        <= 1'b1;
            frame_count <= 16'(frame_count + 16'd1);
          end else begin
            idx   <= idx_next;
            state <= ENTRY_MASK[idx_next] ? READ : SKIP;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus steering: CPU passthrough when idle, table access otherwise.
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    wren_mux  = 1'b0;
    case (state)
      IDLE: begin
        addr_mux  = mif.cpu_address;
        wdata_mux = mif.cpu_data;
        wren_mux  = mif.cpu_wren;
      end
      READ:  addr_mux = src_addr(idx);
      WRITE: begin
        addr_mux  = dst_addr(idx);
        wdata_mux = hold;
        wren_mux  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mif.bus_address = addr_mux;
  assign mif.bus_wdata   = wdata_mux;
  assign mif.bus_wren    = wren_mux;
  assign mif.cpu_q       = mif.bus_rdata;
  assign mif.cpu_stall   = busy;

endmodule
